calc_controller: RTL

CALC_CONTROLLER -- requirements
Module: calc_controller

---
 rtl/calc_pkg.sv | 22 ++
 rtl/btn_conditioner.sv | 66 ++++++
 rtl/calc_controller.sv | 115 +++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared state encodings, digit limit and default timing constants for the calculator controller.
// Latency: n/a (package only).
// Backpressure: n/a.
package calc_pkg;

  typedef enum logic [1:0] {
    ENTRY_A = 2'b00,
    ENTRY_B = 2'b01,
    RESULT  = 2'b10
  } calc_state_t;

  localparam logic [3:0] MAX_DIGIT               = 4'd9;
  localparam int         SCAN_DIV_DEFAULT        = 50000;
  localparam int         DEBOUNCE_CYCLES_DEFAULT = 20000;
  // Wide enough for counts up to 2^20.
  localparam int         CNT_W                   = 21;

  function automatic logic [3:0] next_digit(input logic [3:0] d);
    return (d >= MAX_DIGIT) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Button conditioner: 2-flop sync, optional debounce (CALC_DEBOUNCE_EN), rising-edge one-shot.
// Latency: pulse acts on the 3rd edge after first sample (3+DEBOUNCE_CYCLES with debounce).
// Backpressure: none; one pulse per press, hold time irrelevant.
module btn_conditioner
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_debounce_range
    $error("btn_conditioner: DEBOUNCE_CYCLES out of range");
  end

  logic sync1;
  logic sync2;
  logic filt;
  logic hist;

  // Reset-to-1 so a button held through reset looks already pressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef CALC_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [CNT_W-1:0] deb_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt    <= 1'b1;
      deb_cnt <= '0;
    end else if (sync2 == filt) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      filt    <= sync2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + CNT_W'(1);
    end
  end
`else
  assign filt = sync2;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= 1'b1;
    end else begin
      hist <= filt;
    end
  end

  assign pulse = filt & ~hist;

endmodule

// File: rtl/calc_controller.sv
// Calculator entry sequencer: operand entry A/B, result display, add/sub mode and digit scan.
// Latency: registered outputs update on the 3rd edge after a button is first sampled high.
// Backpressure: none; coincident pulses resolved enter > op > inc, losers discarded.
module calc_controller
  import calc_pkg::*;
#(
  parameter int SCAN_DIV        = SCAN_DIV_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_inc,
  input  logic       btn_enter,
  input  logic       btn_op,
  output logic [3:0] operand_a,
  output logic [3:0] operand_b,
  output logic       mode_select,
  output logic       equals_sel,
  output logic       digit_sel,
  output logic [1:0] state
);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

  logic inc_p;
  logic enter_p;
  logic op_p;
  calc_state_t      cur_state;
  logic [CNT_W-1:0] scan_cnt;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_inc (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_inc),
    .pulse (inc_p)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_enter (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_enter),
    .pulse (enter_p)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_op (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_op),
    .pulse (op_p)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state   <= ENTRY_A;
      operand_a   <= 4'd0;
      operand_b   <= 4'd0;
      mode_select <= 1'b0;
      equals_sel  <= 1'b0;
    end else begin
      case (cur_state)
        ENTRY_A: begin
          if (enter_p) begin
            cur_state  <= ENTRY_B;
            equals_sel <= 1'b0;
          end else if (op_p) begin
            mode_select <= ~mode_select;
          end else if (inc_p) begin
            operand_a <= next_digit(operand_a);
          end
        end
        ENTRY_B: begin
          if (enter_p) begin
            cur_state  <= RESULT;
            equals_sel <= 1'b1;
          end else if (op_p) begin
            mode_select <= ~mode_select;
          end else if (inc_p) begin
            operand_b <= next_digit(operand_b);
          end
        end
        RESULT: begin
          if (enter_p) begin
            cur_state  <= ENTRY_A;
            equals_sel <= 1'b0;
            operand_a  <= 4'd0;
            operand_b  <= 4'd0;
          end else if (op_p) begin
            mode_select <= ~mode_select;
          end
        end
        // Illegal encoding: fall back to operand entry, keep operands and mode.
        default: begin
          cur_state  <= ENTRY_A;
          equals_sel <= 1'b0;
        end
      endcase
    end
  end

  assign state = cur_state;

  // Free-running display scan, independent of the sequencer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_sel <= 1'b0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_sel <= ~digit_sel;
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

endmodule
